// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory arbiter: FSM states, port select, bus widths.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;
    localparam int WORD_W = 32;
    localparam int ADR_W  = 30;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {SEL_I, SEL_D} sel_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// I-fetch port, D load/store port and single-port memory bundle around mem_arbiter.
// Latency: n/a (wires only).
// Backpressure: requests are held by the master until the matching gnt.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              i_req;
    logic [WORD_W-1:0] i_adr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [WORD_W-1:0] i_rdata;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [WORD_W-1:0] d_adr;
    logic [WORD_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [WORD_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADR_W-1:0]  mem_adr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_adr, d_req, d_we, d_adr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, i_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_en, mem_we, mem_adr, mem_wdata
    );

    modport master (
        output i_req, i_adr, d_req, d_we, d_adr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_en, mem_we, mem_adr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection between I and D requests; MEM_ARB_RR_EN gives round-robin ties, else D priority with starvation override.
// Latency: combinational.
// Backpressure: none; the caller decides whether a grant may be issued this cycle.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
`ifdef MEM_ARB_RR_EN
    input  sel_t last_sel,
`else
    input  logic starve_hit,
`endif
    output logic any_req,
    output sel_t sel
);
    assign any_req = i_req | d_req;

    always_comb begin
        sel = SEL_D;
        if (i_req && !d_req) begin
            sel = SEL_I;
        end else if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            sel = (last_sel == SEL_D) ? SEL_I : SEL_D;
`else
            sel = starve_hit ? SEL_I : SEL_D;
`endif
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between I-fetch and D load/store ports; MEM_ARB_RR_EN selects round-robin ties.
// Latency: gnt combinational in the request cycle, rvalid/rdata/err registered LATENCY+1 cycles after gnt.
// Backpressure: one access in flight; requests wait for gnt, next grant may overlap the response cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int SIZE       = 64,
    parameter int LATENCY    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    state_t           state;
    logic [1:0]       lat_cnt;
    sel_t             owner;
    logic             owner_we;
    logic             owner_err;
    logic             any_req;
    sel_t             sel;
    logic             gnt;
    logic [ADR_W-1:0] sel_wadr;
    logic             in_rng;
    logic             sel_we;
    logic             mem_en_c;
    logic             mem_we_c;

    // Reset gating keeps the combinational grant path low while reset_n is asserted.
    assign gnt      = reset_n && any_req && (state == IDLE || state == RESP);
    assign sel_wadr = (sel == SEL_I) ? bus.i_adr[WORD_W-1:2] : bus.d_adr[WORD_W-1:2];
    assign in_rng   = (sel_wadr < ADR_W'(SIZE));
    assign sel_we   = (sel == SEL_D) && bus.d_we;
    assign mem_en_c = gnt && in_rng;
    assign mem_we_c = mem_en_c && sel_we;

    assign bus.i_gnt     = gnt && (sel == SEL_I);
    assign bus.d_gnt     = gnt && (sel == SEL_D);
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_adr   = mem_en_c ? sel_wadr : '0;
    assign bus.mem_wdata = mem_we_c ? bus.d_wdata : '0;

`ifdef MEM_ARB_RR_EN
    sel_t last_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_sel <= SEL_I;
        end else if (gnt) begin
            last_sel <= sel;
        end
    end

    mem_arb_pick u_pick (
        .i_req    (bus.i_req),
        .d_req    (bus.d_req),
        .last_sel (last_sel),
        .any_req  (any_req),
        .sel      (sel)
    );
`else
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));

    // Counts D grants that overtook a waiting I request; saturates at STARVE_MAX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (gnt) begin
            if (sel == SEL_I) begin
                starve_cnt <= '0;
            end else if (bus.i_req && !starve_hit) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    mem_arb_pick u_pick (
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
        .starve_hit (starve_hit),
        .any_req    (any_req),
        .sel        (sel)
    );
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            owner        <= SEL_I;
            owner_we     <= 1'b0;
            owner_err    <= 1'b0;
            bus.i_rvalid <= 1'b0;
            bus.i_rdata  <= '0;
            bus.i_err    <= 1'b0;
            bus.d_rvalid <= 1'b0;
            bus.d_rdata  <= '0;
            bus.d_err    <= 1'b0;
        end else begin
            bus.i_rvalid <= 1'b0;
            bus.i_rdata  <= '0;
            bus.i_err    <= 1'b0;
            bus.d_rvalid <= 1'b0;
            bus.d_rdata  <= '0;
            bus.d_err    <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (gnt) begin
                        state     <= ACCESS;
                        lat_cnt   <= 2'(LATENCY - 1);
                        owner     <= sel;
                        owner_we  <= sel_we;
                        owner_err <= !in_rng;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (lat_cnt == 2'd0) begin
                        state <= RESP;
                        // Out-of-range and store responses carry no data.
                        if (owner == SEL_I) begin
                            bus.i_rvalid <= 1'b1;
                            bus.i_err    <= owner_err;
                            bus.i_rdata  <= owner_err ? '0 : bus.mem_rdata;
                        end else begin
                            bus.d_rvalid <= 1'b1;
                            bus.d_err    <= owner_err;
                            bus.d_rdata  <= (owner_err || owner_we) ? '0 : bus.mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
